// File: rtl/mult_issue_sched_pkg.sv
// Types and constants shared by the multiply issue scheduler and its callers.
// The completion entry is the payload one finished multiply carries to the CDB.
package mult_issue_sched_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int ROB_W = 5;

  localparam logic [4:0] ALU_MUL    = 5'h0a;
  localparam logic [4:0] ALU_MULH   = 5'h0b;
  localparam logic [4:0] ALU_MULHSU = 5'h0c;
  localparam logic [4:0] ALU_MULHU  = 5'h0d;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  value;
  } cq_entry_t;

endpackage

// File: rtl/mult_issue_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr_q upward.
// The pointer moves past the winner only when a grant is issued; en_i low blocks all grants.
module mult_issue_sched_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Two passes: lanes at or above the pointer first, then the wrapped-around lanes.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en_i && !found && req_i[i] && (i >= int'(ptr_q))) begin
        grant_o[i] = 1'b1;
        ptr_d      = PW'((i + 1) % NUM_REQ);
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en_i && !found && req_i[i] && (i < int'(ptr_q))) begin
        grant_o[i] = 1'b1;
        ptr_d      = PW'((i + 1) % NUM_REQ);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mult_issue_sched.sv
// Shares one MULT_LAT-deep multiplier among NUM_REQ lanes; issue is same-cycle, result reaches the CDB one cycle after mult_done.
// Grants are credit-gated so the completion queue cannot overflow while cdb_ack is low; MULT_SCHED_PERF_EN adds perf counters.
module mult_issue_sched
  import mult_issue_sched_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int MULT_LAT = 4,
  parameter int CQ_DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*XLEN-1:0]  req_opa,
  input  logic [NUM_REQ*XLEN-1:0]  req_opb,
  input  logic [NUM_REQ*5-1:0]     req_func,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic [NUM_REQ*ROB_W-1:0] req_rob,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic                     mult_start,
  output logic [XLEN-1:0]          mult_mcand,
  output logic [XLEN-1:0]          mult_mplier,
  output logic [4:0]               mult_func,
  input  logic [XLEN-1:0]          mult_result,
  input  logic                     mult_done,
  input  logic                     squash,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [ROB_W-1:0]         cdb_rob,
  output logic [XLEN-1:0]          cdb_value,
  input  logic                     cdb_ack,
  output logic                     sched_busy
`ifdef MULT_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_issued,
  output logic [31:0]              perf_credit_stall,
  output logic [31:0]              perf_squashed
`endif
);

  localparam int AW = $clog2(CQ_DEPTH);

  logic [MULT_LAT-1:0] pipe_vld_q;
  logic [TAG_W-1:0]    pipe_tag_q [MULT_LAT];
  logic [ROB_W-1:0]    pipe_rob_q [MULT_LAT];
  cq_entry_t           cq_mem_q   [CQ_DEPTH];
  logic [AW-1:0]       head_q, tail_q;
  logic [AW:0]         count_q;
  int unsigned         inflight_cnt, occupancy;
  logic                credit_ok, grant_en, push, pop;
  logic [TAG_W-1:0]    iss_tag;
  logic [ROB_W-1:0]    iss_rob;

  always_comb begin
    inflight_cnt = 0;
    for (int i = 0; i < MULT_LAT; i++) inflight_cnt += 32'(pipe_vld_q[i]);
  end

  // Every op holds a credit from issue until the CDB pops it.
  assign occupancy = inflight_cnt + 32'(count_q);
  assign credit_ok = occupancy < 32'(CQ_DEPTH);
  assign grant_en  = credit_ok & ~squash & ~reset;

  mult_issue_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req_i   (req_valid),
    .en_i    (grant_en),
    .grant_o (req_grant)
  );

  always_comb begin
    mult_mcand  = '0;
    mult_mplier = '0;
    mult_func   = '0;
    iss_tag     = '0;
    iss_rob     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_grant[i]) begin
        mult_mcand  = req_opa[i*XLEN +: XLEN];
        mult_mplier = req_opb[i*XLEN +: XLEN];
        mult_func   = req_func[i*5 +: 5];
        iss_tag     = req_tag[i*TAG_W +: TAG_W];
        iss_rob     = req_rob[i*ROB_W +: ROB_W];
      end
    end
  end

  assign mult_start = |req_grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       pipe_vld_q <= '0;
    else if (squash) pipe_vld_q <= '0;
    else             pipe_vld_q <= {pipe_vld_q[MULT_LAT-2:0], mult_start};
  end

  always_ff @(posedge clock) begin
    pipe_tag_q[0] <= iss_tag;
    pipe_rob_q[0] <= iss_rob;
    for (int i = 1; i < MULT_LAT; i++) begin
      pipe_tag_q[i] <= pipe_tag_q[i-1];
      pipe_rob_q[i] <= pipe_rob_q[i-1];
    end
  end

  assign push = mult_done & pipe_vld_q[MULT_LAT-1] & ~squash;
  assign pop  = cdb_ack & (count_q != '0) & ~squash;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (squash) begin
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) cq_mem_q[tail_q] <= '{tag: pipe_tag_q[MULT_LAT-1], rob: pipe_rob_q[MULT_LAT-1], value: mult_result};
  end

  assign cdb_valid  = (count_q != '0);
  assign cdb_tag    = cdb_valid ? cq_mem_q[head_q].tag   : '0;
  assign cdb_rob    = cdb_valid ? cq_mem_q[head_q].rob   : '0;
  assign cdb_value  = cdb_valid ? cq_mem_q[head_q].value : '0;
  assign sched_busy = cdb_valid | (|pipe_vld_q);

`ifndef SYNTHESIS
  // Unreset start history: results of squashed or reset-killed ops may still emerge, but never a done without a start.
  logic [MULT_LAT-1:0] start_hist_q;
  always_ff @(posedge clock) begin
    start_hist_q <= {start_hist_q[MULT_LAT-2:0], mult_start};
    assert (!(mult_done && !pipe_vld_q[MULT_LAT-1] && !start_hist_q[MULT_LAT-1]))
      else $error("mult_done without a matching issue MULT_LAT cycles earlier");
  end
`endif

`ifdef MULT_SCHED_PERF_EN
  logic [32:0] squash_sum;
  assign squash_sum = {1'b0, perf_squashed} + 33'(occupancy);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issued       <= '0;
      perf_credit_stall <= '0;
      perf_squashed     <= '0;
    end else begin
      if (mult_start && (perf_issued != '1)) perf_issued <= perf_issued + 1'b1;
      if ((|req_valid) && !credit_ok && (perf_credit_stall != '1))
        perf_credit_stall <= perf_credit_stall + 1'b1;
      if (squash) perf_squashed <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_mult_issue_sched.sv
// Directed bench for mult_issue_sched with a fixed-latency multiplier model driving mult_done/mult_result.
module tb_mult_issue_sched;
  import mult_issue_sched_pkg::*;

  localparam int NR  = 3;
  localparam int LAT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*32-1:0]  req_opa, req_opb;
  logic [NR*5-1:0]   req_func;
  logic [NR*6-1:0]   req_tag;
  logic [NR*5-1:0]   req_rob;
  logic [NR-1:0]     req_grant;
  logic              mult_start;
  logic [31:0]       mult_mcand, mult_mplier;
  logic [4:0]        mult_func;
  logic [31:0]       mult_result;
  logic              mult_done;
  logic              squash;
  logic              cdb_valid;
  logic [5:0]        cdb_tag;
  logic [4:0]        cdb_rob;
  logic [31:0]       cdb_value;
  logic              cdb_ack;
  logic              sched_busy;
`ifdef MULT_SCHED_PERF_EN
  logic [31:0]       perf_issued, perf_credit_stall, perf_squashed;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int ng;
  logic [2:0] expg;
  logic [4:0] fn [3];

  always #5 clock = ~clock;

  mult_issue_sched #(.NUM_REQ(NR), .MULT_LAT(LAT), .CQ_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_opa(req_opa), .req_opb(req_opb),
    .req_func(req_func), .req_tag(req_tag), .req_rob(req_rob), .req_grant(req_grant),
    .mult_start(mult_start), .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
    .mult_func(mult_func), .mult_result(mult_result), .mult_done(mult_done), .squash(squash),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .cdb_ack(cdb_ack), .sched_busy(sched_busy)
`ifdef MULT_SCHED_PERF_EN
    , .perf_issued(perf_issued), .perf_credit_stall(perf_credit_stall), .perf_squashed(perf_squashed)
`endif
  );

  // Multiplier FU model: fixed latency, never reset, result = low product.
  logic [LAT-1:0] fu_v = '0;
  logic [31:0]    fu_r [LAT];
  always @(posedge clock) begin
    fu_v    <= {fu_v[LAT-2:0], mult_start};
    fu_r[0] <= mult_mcand * mult_mplier;
    for (int i = 1; i < LAT; i++) fu_r[i] <= fu_r[i-1];
  end
  assign mult_done   = fu_v[LAT-1];
  assign mult_result = fu_r[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] f, input logic [5:0] t, input logic [4:0] r);
    req_opa[i*32 +: 32] = a;
    req_opb[i*32 +: 32] = b;
    req_func[i*5 +: 5]  = f;
    req_tag[i*6 +: 6]   = t;
    req_rob[i*5 +: 5]   = r;
  endtask

  task automatic std_lanes();
    for (int i = 0; i < NR; i++) set_lane(i, 32'(i + 2), 32'd10, fn[i], 6'(30 + i), 5'(i));
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (sched_busy !== 1'b0 && c < 40) begin
      step();
      mid();
      c++;
    end
    chk(tag, sched_busy, 0);
  endtask

  initial begin
    fn[0] = ALU_MUL; fn[1] = ALU_MULH; fn[2] = ALU_MULHSU;
    reset = 1'b1; squash = 1'b0; cdb_ack = 1'b0;
    req_opa = '0; req_opb = '0; req_func = '0; req_tag = '0; req_rob = '0;
    std_lanes();
    req_valid = 3'b111;
    mid();
    chk("rst_grant", req_grant, 0);
    chk("rst_start", mult_start, 0);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_mcand", mult_mcand, 0);
    step();
    reset = 1'b0; req_valid = '0;

    // Fairness: all lanes request, ack held; first six grants rotate 0,1,2,0,1,2.
    step();
    cdb_ack = 1'b1; req_valid = 3'b111;
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      mid();
      if (req_grant != '0) begin
        expg = 3'b001 << (ng % 3);
        chk("fair_grant", req_grant, expg);
        chk("fair_func", mult_func, fn[ng % 3]);
        ng++;
      end
      if (ng == 6) break;
      step();
    end
    chk("fair_count", ng, 6);
    step();
    req_valid = '0;
    wait_idle("fair_idle");

    // Back-to-back ops with ack each cycle: push and pop coincide, one completion per cycle.
    step();
    set_lane(0, 32'd3, 32'd5, ALU_MUL, 6'd20, 5'd1);
    req_valid = 3'b001;
    mid();
    chk("pp_grant0", req_grant, 3'b001);
    step();
    set_lane(1, 32'd4, 32'd9, ALU_MULHU, 6'd21, 5'd2);
    req_valid = 3'b010;
    mid();
    chk("pp_grant1", req_grant, 3'b010);
    chk("pp_func1", mult_func, ALU_MULHU);
    step(); req_valid = '0;
    step(); step();
    mid();
    chk("pp_c4_valid", cdb_valid, 0);
    step(); mid();
    chk("pp_c5_valid", cdb_valid, 1);
    chk("pp_c5_tag", cdb_tag, 20);
    chk("pp_c5_value", cdb_value, 15);
    step(); mid();
    chk("pp_c6_valid", cdb_valid, 1);
    chk("pp_c6_tag", cdb_tag, 21);
    chk("pp_c6_value", cdb_value, 36);
    step(); mid();
    chk("pp_c7_valid", cdb_valid, 0);
    chk("pp_c7_busy", sched_busy, 0);

    // Single request on lane 1: 7*6, tag 5.
    step();
    cdb_ack = 1'b0;
    set_lane(1, 32'd7, 32'd6, ALU_MUL, 6'd5, 5'd3);
    req_valid = 3'b010;
    mid();
    chk("one_grant", req_grant, 3'b010);
    chk("one_start", mult_start, 1);
    chk("one_mcand", mult_mcand, 7);
    chk("one_mplier", mult_mplier, 6);
    chk("one_func", mult_func, ALU_MUL);
    step(); req_valid = '0;
    mid();
    chk("one_start_once", mult_start, 0);
    step(); step(); step();
    mid();
    chk("one_c4_valid", cdb_valid, 0);
    step();
    cdb_ack = 1'b1;
    mid();
    chk("one_c5_valid", cdb_valid, 1);
    chk("one_c5_tag", cdb_tag, 5);
    chk("one_c5_rob", cdb_rob, 3);
    chk("one_c5_value", cdb_value, 42);
    step(); mid();
    chk("one_drained", sched_busy, 0);

    // Backpressure: ack low for 20 cycles allows exactly four grants (pointer at 2).
    step();
    std_lanes();
    cdb_ack = 1'b0; req_valid = 3'b111;
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      mid();
      if (req_grant != '0) ng++;
      step();
    end
    chk("bp_grants", ng, 4);
    cdb_ack = 1'b1;
    mid();
    chk("bp_d0_grant", req_grant, 0);
    chk("bp_d0_tag", cdb_tag, 32);
    chk("bp_d0_value", cdb_value, 40);
    step(); mid();
    chk("bp_d1_tag", cdb_tag, 30);
    chk("bp_d1_value", cdb_value, 20);
    chk("bp_d1_grant", req_grant, 3'b001);
    step(); mid();
    chk("bp_d2_tag", cdb_tag, 31);
    chk("bp_d2_grant", req_grant, 3'b010);
    step(); mid();
    chk("bp_d3_tag", cdb_tag, 32);
    chk("bp_d3_grant", req_grant, 3'b100);
    step(); mid();
    chk("bp_d4_valid", cdb_valid, 0);
    chk("bp_d4_grant", req_grant, 3'b001);
    step();
    req_valid = '0;
    wait_idle("bp_idle");

    // Squash two cycles after three issues (pointer at 1).
    step();
    req_valid = 3'b111;
    mid(); chk("sq_g0", req_grant, 3'b010);
    step(); mid(); chk("sq_g1", req_grant, 3'b100);
    step(); mid(); chk("sq_g2", req_grant, 3'b001);
    step(); req_valid = '0;
    mid(); chk("sq_busy_pre", sched_busy, 1);
    step();
    squash = 1'b1; req_valid = 3'b111;
    mid();
    chk("sq_no_grant", req_grant, 0);
    step();
    squash = 1'b0;
    mid();
    chk("sq_regrant", req_grant, 3'b010);
    chk("sq_busy_post", sched_busy, 0);
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      mid();
      chk("sq_no_cdb", cdb_valid, 0);
    end
    step(); mid();
    chk("sq_new_valid", cdb_valid, 1);
    chk("sq_new_tag", cdb_tag, 31);
    chk("sq_new_value", cdb_value, 30);
    step(); mid();
    chk("sq_idle", sched_busy, 0);

    // Async reset with two ops in flight (pointer at 2).
    step();
    req_valid = 3'b111;
    mid(); chk("ar_g0", req_grant, 3'b100);
    step(); mid(); chk("ar_g1", req_grant, 3'b001);
    step(); req_valid = '0;
    mid(); chk("ar_busy_pre", sched_busy, 1);
    #2;
    reset = 1'b1; req_valid = 3'b111;
    #1;
    chk("ar_busy_clr", sched_busy, 0);
    chk("ar_grant_clr", req_grant, 0);
    chk("ar_start_clr", mult_start, 0);
    chk("ar_cdb_clr", cdb_valid, 0);
    step(); step();
    reset = 1'b0; req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      mid();
      chk("ar_late_done", cdb_valid, 0);
      step();
    end
    chk("ar_idle", sched_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
